// File: rtl/axi_lite_reg_responder_pkg.sv
// Shared definitions for the AXI4-Lite register responder.
//   - response codes returned on BRESP / RRESP
//   - write and read channel FSM state encodings
//   - byte-lane merge helper used when committing a strobed write
package axi_lite_reg_responder_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_RESP = 1'b1
   } w_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_RESP = 1'b1
   } r_state_e;

   // Replace only the byte lanes whose strobe bit is set.
   function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) begin
            res[8*i +: 8] = new_val[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_val[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/axi_lite_reg_responder_addr_decode.sv
// Combinational address decoder for the register window.
// Ports:
//   addr      in   32        byte address
//   in_range  out  1         address falls inside [BASE_ADDR, BASE_ADDR + NUM_REGS*4)
//   index     out  IDX_W     word index inside the window (addr[1:0] ignored)
module axi_lite_addr_decode
   import axi_lite_reg_responder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
   parameter int          NUM_REGS  = 16,
   parameter int          IDX_W     = $clog2(NUM_REGS)
) (
   input  logic [31:0]      addr,
   output logic             in_range,
   output logic [IDX_W-1:0] index
);

   logic [31:0] offset_s;
   logic        unused_offset_s;

   // Offset wraps for addresses below the base, so the lower-bound test is separate.
   assign offset_s        = addr - BASE_ADDR;
   assign in_range        = (addr >= BASE_ADDR) && (offset_s < (32'(NUM_REGS) << 2));
   assign index           = offset_s[IDX_W+1:2];
   assign unused_offset_s = ^{offset_s[31:IDX_W+2], offset_s[1:0]};

endmodule

// File: rtl/axi_lite_reg_responder.sv
// AXI4-Lite register responder: NUM_REGS x 32-bit registers at BASE_ADDR.
// One outstanding transaction per channel; read and write channels independent.
// Ports (s0_* is the AXI4-Lite subordinate interface):
//   g_clk, g_reset              clock, synchronous active-high reset
//   s0_aw* / s0_w* / s0_b*      write address, write data, write response
//   s0_ar* / s0_r*              read address, read data/response
// Out-of-range accesses return SLVERR (reads return zero data) and change nothing.
module axi_lite_reg_responder
   import axi_lite_reg_responder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
   parameter int          NUM_REGS  = 16,
   parameter logic [31:0] REG_RESET = 32'h0
) (
   input  logic        g_clk,
   input  logic        g_reset,
   input  logic        s0_awvalid,
   output logic        s0_awready,
   input  logic [31:0] s0_awaddr,
   input  logic [2:0]  s0_awprot,
   input  logic        s0_wvalid,
   output logic        s0_wready,
   input  logic [31:0] s0_wdata,
   input  logic [3:0]  s0_wstrb,
   output logic        s0_bvalid,
   input  logic        s0_bready,
   output logic [1:0]  s0_bresp,
   input  logic        s0_arvalid,
   output logic        s0_arready,
   input  logic [31:0] s0_araddr,
   input  logic [2:0]  s0_arprot,
   output logic        s0_rvalid,
   input  logic        s0_rready,
   output logic [1:0]  s0_rresp,
   output logic [31:0] s0_rdata
);

   localparam int IDX_W = $clog2(NUM_REGS);

   w_state_e          w_state_q, w_state_d;
   r_state_e          r_state_q, r_state_d;
   logic              aw_held_q, aw_held_d;
   logic              w_held_q, w_held_d;
   logic [31:0]       awaddr_q, awaddr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic [1:0]        bresp_q, bresp_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;
   logic [31:0]       regs_q [NUM_REGS];
   logic [31:0]       regs_d [NUM_REGS];

   logic              aw_hs_s, w_hs_s, ar_hs_s;
   logic [31:0]       wr_addr_s, wr_data_s;
   logic [3:0]        wr_strb_s;
   logic              commit_s;
   logic              wr_in_range_s, rd_in_range_s;
   logic [IDX_W-1:0]  wr_idx_s, rd_idx_s;
   logic              unused_prot_s;

   // Readies come only from state and reset, never from a valid input.
   assign s0_awready = !g_reset && (w_state_q == W_IDLE) && !aw_held_q;
   assign s0_wready  = !g_reset && (w_state_q == W_IDLE) && !w_held_q;
   assign s0_arready = !g_reset && (r_state_q == R_IDLE);
   assign s0_bvalid  = (w_state_q == W_RESP);
   assign s0_bresp   = bresp_q;
   assign s0_rvalid  = (r_state_q == R_RESP);
   assign s0_rresp   = rresp_q;
   assign s0_rdata   = rdata_q;

   assign aw_hs_s = s0_awvalid && s0_awready;
   assign w_hs_s  = s0_wvalid && s0_wready;
   assign ar_hs_s = s0_arvalid && s0_arready;

   // A handshake on this edge bypasses the holding register so the write can
   // commit on the same edge as the later of AW/W.
   assign wr_addr_s = aw_hs_s ? s0_awaddr : awaddr_q;
   assign wr_data_s = w_hs_s  ? s0_wdata  : wdata_q;
   assign wr_strb_s = w_hs_s  ? s0_wstrb  : wstrb_q;

   assign unused_prot_s = ^{s0_awprot, s0_arprot};

   axi_lite_addr_decode #(
      .BASE_ADDR (BASE_ADDR),
      .NUM_REGS  (NUM_REGS),
      .IDX_W     (IDX_W)
   ) u_wr_decode (
      .addr     (wr_addr_s),
      .in_range (wr_in_range_s),
      .index    (wr_idx_s)
   );

   axi_lite_addr_decode #(
      .BASE_ADDR (BASE_ADDR),
      .NUM_REGS  (NUM_REGS),
      .IDX_W     (IDX_W)
   ) u_rd_decode (
      .addr     (s0_araddr),
      .in_range (rd_in_range_s),
      .index    (rd_idx_s)
   );

   // Write channel next-state: capture AW/W independently, commit when both are held.
   always_comb begin
      w_state_d = w_state_q;
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bresp_d   = bresp_q;
      commit_s  = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (aw_hs_s) begin
               aw_held_d = 1'b1;
               awaddr_d  = s0_awaddr;
            end else begin
               aw_held_d = aw_held_q;
            end
            if (w_hs_s) begin
               w_held_d = 1'b1;
               wdata_d  = s0_wdata;
               wstrb_d  = s0_wstrb;
            end else begin
               w_held_d = w_held_q;
            end
            if ((aw_held_q || aw_hs_s) && (w_held_q || w_hs_s)) begin
               commit_s  = 1'b1;
               w_state_d = W_RESP;
               bresp_d   = wr_in_range_s ? RESP_OKAY : RESP_SLVERR;
            end else begin
               w_state_d = W_IDLE;
            end
         end
         W_RESP: begin
            if (s0_bready) begin
               w_state_d = W_IDLE;
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
               bresp_d   = RESP_OKAY;
            end else begin
               w_state_d = W_RESP;
            end
         end
         default: begin
            w_state_d = W_IDLE;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bresp_d   = RESP_OKAY;
         end
      endcase
   end

   // Register file next-state: strobed merge on an in-range commit.
   always_comb begin
      regs_d = regs_q;
      if (commit_s && wr_in_range_s) begin
         regs_d[wr_idx_s] = apply_wstrb(regs_q[wr_idx_s], wr_data_s, wr_strb_s);
      end else begin
         regs_d = regs_q;
      end
   end

   // Read channel next-state: data sampled from regs_q, so a same-edge write is not seen.
   always_comb begin
      r_state_d = r_state_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (r_state_q)
         R_IDLE: begin
            if (ar_hs_s) begin
               r_state_d = R_RESP;
               if (rd_in_range_s) begin
                  rdata_d = regs_q[rd_idx_s];
                  rresp_d = RESP_OKAY;
               end else begin
                  rdata_d = 32'h0;
                  rresp_d = RESP_SLVERR;
               end
            end else begin
               r_state_d = R_IDLE;
            end
         end
         R_RESP: begin
            if (s0_rready) begin
               r_state_d = R_IDLE;
               rdata_d   = 32'h0;
               rresp_d   = RESP_OKAY;
            end else begin
               r_state_d = R_RESP;
            end
         end
         default: begin
            r_state_d = R_IDLE;
            rdata_d   = 32'h0;
            rresp_d   = RESP_OKAY;
         end
      endcase
   end

   // State, holding registers, response registers and register file.
   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         awaddr_q  <= 32'h0;
         wdata_q   <= 32'h0;
         wstrb_q   <= 4'h0;
         bresp_q   <= RESP_OKAY;
         rdata_q   <= 32'h0;
         rresp_q   <= RESP_OKAY;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= REG_RESET;
         end
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bresp_q   <= bresp_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_reg_responder.sv
module tb_axi_lite_reg_responder;

   localparam logic [31:0] BASE = 32'h4000_0000;

   logic        g_clk = 1'b0;
   logic        g_reset = 1'b1;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic [31:0] awaddr = 32'h0, wdata = 32'h0, araddr = 32'h0;
   logic [3:0]  wstrb = 4'h0;
   logic [2:0]  awprot = 3'h0, arprot = 3'h0;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;

   int checks = 0;
   int errors = 0;

   axi_lite_reg_responder dut (
      .g_clk      (g_clk),
      .g_reset    (g_reset),
      .s0_awvalid (awvalid),
      .s0_awready (awready),
      .s0_awaddr  (awaddr),
      .s0_awprot  (awprot),
      .s0_wvalid  (wvalid),
      .s0_wready  (wready),
      .s0_wdata   (wdata),
      .s0_wstrb   (wstrb),
      .s0_bvalid  (bvalid),
      .s0_bready  (bready),
      .s0_bresp   (bresp),
      .s0_arvalid (arvalid),
      .s0_arready (arready),
      .s0_araddr  (araddr),
      .s0_arprot  (arprot),
      .s0_rvalid  (rvalid),
      .s0_rready  (rready),
      .s0_rresp   (rresp),
      .s0_rdata   (rdata)
   );

   always #5 g_clk = ~g_clk;

   task automatic tick();
      @(posedge g_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Simultaneous AW+W; response accepted immediately.
   task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [1:0] exp_resp);
      awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      chk({tag, "_bvalid"}, bvalid, 1);
      chk({tag, "_bresp"}, bresp, exp_resp);
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk({tag, "_bvalid_lo"}, bvalid, 0);
      chk({tag, "_bresp_idle"}, bresp, 0);
      chk({tag, "_awready_back"}, awready, 1);
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp_data,
                     input logic [1:0] exp_resp);
      arvalid = 1'b1; araddr = a;
      tick();
      arvalid = 1'b0;
      chk({tag, "_rvalid"}, rvalid, 1);
      chk({tag, "_rdata"}, rdata, exp_data);
      chk({tag, "_rresp"}, rresp, exp_resp);
      rready = 1'b1;
      tick();
      rready = 1'b0;
      chk({tag, "_rvalid_lo"}, rvalid, 0);
      chk({tag, "_rdata_idle"}, rdata, 0);
      chk({tag, "_rresp_idle"}, rresp, 0);
   endtask

   initial begin
      // Reset held three edges: everything quiet.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_awready", awready, 0);
         chk("rst_arready", arready, 0);
         chk("rst_bvalid", bvalid, 0);
         chk("rst_rvalid", rvalid, 0);
         chk("rst_rdata", rdata, 0);
      end
      g_reset = 1'b0;
      #1;
      chk("post_rst_awready", awready, 1);
      chk("post_rst_wready", wready, 1);
      chk("post_rst_arready", arready, 1);

      rd("reset_idx5", BASE + 32'h14, 32'h0, 2'b00);

      // AW two cycles ahead of W.
      awvalid = 1'b1; awaddr = BASE + 32'h8;
      tick();
      awvalid = 1'b0;
      chk("aw_first_awready", awready, 0);
      chk("aw_first_wready", wready, 1);
      chk("aw_first_bvalid0", bvalid, 0);
      tick();
      chk("aw_first_bvalid1", bvalid, 0);
      wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
      tick();
      wvalid = 1'b0;
      chk("aw_first_bvalid", bvalid, 1);
      chk("aw_first_bresp", bresp, 0);
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk("aw_first_done", bvalid, 0);
      rd("aw_first_rb", BASE + 32'h8, 32'hDEAD_BEEF, 2'b00);

      // W one cycle ahead of AW.
      wvalid = 1'b1; wdata = 32'h0000_600D; wstrb = 4'hF;
      tick();
      wvalid = 1'b0;
      chk("w_first_wready", wready, 0);
      chk("w_first_bvalid0", bvalid, 0);
      awvalid = 1'b1; awaddr = BASE + 32'h18;
      tick();
      awvalid = 1'b0;
      chk("w_first_bvalid", bvalid, 1);
      bready = 1'b1;
      tick();
      bready = 1'b0;
      rd("w_first_rb", BASE + 32'h18, 32'h0000_600D, 2'b00);

      // Byte strobes, then an empty strobe.
      wr("strb_init", BASE + 32'hC, 32'h1122_3344, 4'hF, 2'b00);
      wr("strb_0101", BASE + 32'hC, 32'hAABB_CCDD, 4'b0101, 2'b00);
      rd("strb_rb", BASE + 32'hC, 32'h11BB_33DD, 2'b00);
      wr("strb_none", BASE + 32'hC, 32'hFFFF_FFFF, 4'h0, 2'b00);
      rd("strb_none_rb", BASE + 32'hC, 32'h11BB_33DD, 2'b00);

      // Out of range on both sides of the window.
      wr("last_reg", BASE + 32'h3C, 32'hCAFE_F00D, 4'hF, 2'b00);
      wr("oor_wr", BASE + 32'h40, 32'h1234_5678, 4'hF, 2'b10);
      rd("oor_rd", BASE + 32'h40, 32'h0, 2'b10);
      rd("below_rd", BASE - 32'h4, 32'h0, 2'b10);
      rd("oor_reg0", BASE, 32'h0, 2'b00);
      rd("oor_reg15", BASE + 32'h3C, 32'hCAFE_F00D, 2'b00);

      // Back-pressure on both channels for five cycles.
      awvalid = 1'b1; awaddr = BASE + 32'h10; wvalid = 1'b1; wdata = 32'h55AA; wstrb = 4'hF;
      arvalid = 1'b1; araddr = BASE + 32'h8;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_bvalid", bvalid, 1);
         chk("bp_bresp", bresp, 0);
         chk("bp_rvalid", rvalid, 1);
         chk("bp_rdata", rdata, 32'hDEAD_BEEF);
         chk("bp_readies", {29'h0, awready, wready, arready}, 0);
         tick();
      end
      bready = 1'b1; rready = 1'b1;
      tick();
      bready = 1'b0; rready = 1'b0;
      chk("bp_bvalid_lo", bvalid, 0);
      chk("bp_rvalid_lo", rvalid, 0);
      rd("bp_wr_rb", BASE + 32'h10, 32'h55AA, 2'b00);

      // Same-edge read and write of reg 2: old value is returned.
      wr("coll_init", BASE + 32'h8, 32'h1, 4'hF, 2'b00);
      awvalid = 1'b1; awaddr = BASE + 32'h8; wvalid = 1'b1; wdata = 32'h2; wstrb = 4'hF;
      arvalid = 1'b1; araddr = BASE + 32'h8;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      chk("coll_rdata", rdata, 32'h1);
      chk("coll_bvalid", bvalid, 1);
      bready = 1'b1; rready = 1'b1;
      tick();
      bready = 1'b0; rready = 1'b0;
      rd("coll_rb", BASE + 32'h8, 32'h2, 2'b00);

      // Reset while a write response is pending.
      awvalid = 1'b1; awaddr = BASE + 32'h1C; wvalid = 1'b1; wdata = 32'h77; wstrb = 4'hF;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      chk("rstw_bvalid", bvalid, 1);
      g_reset = 1'b1;
      tick();
      chk("rstw_bvalid_drop", bvalid, 0);
      chk("rstw_awready", awready, 0);
      g_reset = 1'b0;
      bready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rstw_no_resp", bvalid, 0);
      end
      bready = 1'b0;
      rd("rstw_lost", BASE + 32'h1C, 32'h0, 2'b00);
      rd("rstw_reg2_cleared", BASE + 32'h8, 32'h0, 2'b00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
